// File: rtl/uart_line_buffer_pkg.sv
// Shared types and ASCII constants for the UART line buffer slice.
package uart_line_pkg;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/uart_line_buffer_if.sv
// Receive/transmit handshake bundle between uart_top and the line buffer.
interface uart_line_buffer_if #(
    parameter int DEPTH = 64
);
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic             i_rx_dv;
    logic [7:0]       i_rx_byte;
    logic             i_tx_active;
    logic             i_tx_done;
    logic             o_tx_dv;
    logic [7:0]       o_tx_byte;
    logic             o_busy;
    logic             o_line_done;
    logic [LEN_W-1:0] o_line_len;
    logic [7:0]       o_drop_count;

    modport slave (
        input  i_rx_dv, i_rx_byte, i_tx_active, i_tx_done,
        output o_tx_dv, o_tx_byte, o_busy, o_line_done, o_line_len, o_drop_count
    );

    modport master (
        output i_rx_dv, i_rx_byte, i_tx_active, i_tx_done,
        input  o_tx_dv, o_tx_byte, o_busy, o_line_done, o_line_len, o_drop_count
    );

endinterface

// File: rtl/uart_line_buffer_ram.sv
// DEPTH x 8 line storage: one synchronous write port, one combinational read port.
module line_buf_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_line_buffer.sv
// Collects received bytes into a line, then replays it to the transmitter.
// Define UART_LINE_BUF_UPCASE_EN to upper-case 'a'..'z' on transmit.
module uart_line_buffer
    import uart_line_pkg::*;
#(
    parameter int         DEPTH     = 64,
    parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_line_buffer_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] tx_xform(input logic [7:0] b);
`ifdef UART_LINE_BUF_UPCASE_EN
        if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
            return b - CASE_OFFSET;
        end
        return b;
`else
        return b;
`endif
    endfunction

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt, count_inc;
    logic [AW:0]   line_len, line_len_nxt;
    logic          tx_dv, tx_dv_nxt;
    logic [7:0]    tx_byte, tx_byte_nxt;
    logic          line_done, line_done_nxt;
    logic [7:0]    drop_count, drop_nxt;
    logic          mem_we;
    logic [7:0]    mem_rdata;

    line_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_ptr),
        .i_wdata (bus.i_rx_byte),
        .i_raddr (rd_ptr),
        .o_rdata (mem_rdata)
    );

    assign count_inc = count + 1'b1;

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        line_len_nxt  = line_len;
        tx_dv_nxt     = 1'b0;
        tx_byte_nxt   = tx_byte;
        line_done_nxt = 1'b0;
        drop_nxt      = drop_count;
        mem_we        = 1'b0;

        case (state)
            COLLECT: begin
                if (bus.i_rx_dv) begin
                    mem_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    count_nxt  = count_inc;
                    if (bus.i_rx_byte == TERM_CHAR || count_inc == FULL_CNT) begin
                        line_len_nxt = count_inc;
                        rd_ptr_nxt   = '0;
                        state_nxt    = SEND;
                    end
                end
            end
            SEND: begin
                if (!bus.i_tx_active) begin
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = tx_xform(mem_rdata);
                    state_nxt   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.i_tx_done) begin
                    if ({1'b0, rd_ptr} + 1'b1 == line_len) begin
                        line_done_nxt = 1'b1;
                        wr_ptr_nxt    = '0;
                        rd_ptr_nxt    = '0;
                        count_nxt     = '0;
                        state_nxt     = COLLECT;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 1'b1;
                        state_nxt  = SEND;
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase

        // Anything received while a line is replaying is lost, including a
        // strobe coinciding with the final tx_done.
        if (state != COLLECT && bus.i_rx_dv) begin
            drop_nxt = sat_inc8(drop_count);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            line_len   <= '0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
            line_done  <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            line_len   <= line_len_nxt;
            tx_dv      <= tx_dv_nxt;
            tx_byte    <= tx_byte_nxt;
            line_done  <= line_done_nxt;
            drop_count <= drop_nxt;
        end
    end

    assign bus.o_tx_dv      = tx_dv;
    assign bus.o_tx_byte    = tx_byte;
    assign bus.o_busy       = (state != COLLECT);
    assign bus.o_line_done  = line_done;
    assign bus.o_line_len   = line_len;
    assign bus.o_drop_count = drop_count;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Randomized and directed bench for uart_line_buffer against a queue-based line model.
module tb_uart_line_buffer;
    import uart_line_pkg::*;

    localparam int         DEPTH = 64;
    localparam logic [7:0] TERM  = 8'h0A;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    uart_line_buffer_if #(.DEPTH(DEPTH)) bus ();

    uart_line_buffer #(.DEPTH(DEPTH), .TERM_CHAR(TERM)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic xmit_busy   = 1'b0;
    logic hold_active = 1'b0;
    assign bus.i_tx_active = xmit_busy | hold_active;

    int n_checks = 0;
    int n_pass   = 0;
    int ld_count = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] up(input logic [7:0] b);
`ifdef UART_LINE_BUF_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Behavioural model: a line is a queue; once closed it becomes the expected transmit list.
    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit m_busy = 1'b0;
    bit m_ld   = 1'b0;
    int m_rem  = 0;
    int m_len  = 0;
    int m_drops = 0;

    always @(posedge i_clk) begin
        m_ld = 1'b0;
        if (i_rst) begin
            line_q.delete();
            exp_q.delete();
            m_busy = 1'b0; m_rem = 0; m_len = 0; m_drops = 0;
        end else if (!m_busy) begin
            if (bus.i_rx_dv) begin
                line_q.push_back(bus.i_rx_byte);
                if (bus.i_rx_byte == TERM || line_q.size() == DEPTH) begin
                    foreach (line_q[i]) exp_q.push_back(up(line_q[i]));
                    m_len  = line_q.size();
                    m_rem  = m_len;
                    m_busy = 1'b1;
                    line_q.delete();
                end
            end
        end else begin
            if (bus.i_rx_dv && m_drops < 255) m_drops++;
            if (bus.i_tx_done) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_ld   = 1'b1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (checking) begin
            chk("busy", bus.o_busy, m_busy);
            chk("drop_count", bus.o_drop_count, m_drops);
            chk("line_len", bus.o_line_len, m_len);
            chk("line_done", bus.o_line_done, m_ld);
            if (bus.o_line_done === 1'b1) ld_count++;
            if (bus.o_tx_dv === 1'b1) begin
                chk("tx_dv_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("tx_byte", bus.o_tx_byte, exp_q.pop_front());
                got.push_back(bus.o_tx_byte);
            end
        end
    end

    // Transmitter: done strobe 10 cycles after each start strobe.
    initial begin : xmit
        int cnt;
        cnt = 0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            bus.i_tx_done = 1'b0;
            if (xmit_busy) begin
                cnt--;
                if (cnt == 0) begin
                    xmit_busy = 1'b0;
                    bus.i_tx_done = 1'b1;
                end
            end else if (bus.o_tx_dv === 1'b1) begin
                xmit_busy = 1'b1;
                cnt = 10;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        bus.i_rx_dv = 1'b1;
        bus.i_rx_byte = b;
        @(negedge i_clk);
        bus.i_rx_dv = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_busy || xmit_busy || bus.o_busy) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        chk({name, "_idle_in_time"}, n < 3000, 1);
        chk({name, "_nothing_pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_got(input int target, input string name);
        int n;
        n = 0;
        while (got.size() < target && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        chk({name, "_tx_seen"}, n < 500, 1);
    endtask

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int ld0;
        int len;
        bus.i_rx_dv = 1'b0;
        bus.i_rx_byte = 8'h00;

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_tx_dv", bus.o_tx_dv, 0);
        chk("rst_tx_byte", bus.o_tx_byte, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_line_done", bus.o_line_done, 0);
        chk("rst_line_len", bus.o_line_len, 0);
        chk("rst_drop", bus.o_drop_count, 0);
        checking = 1'b1;

        // "abc\n" with latency pinned at SEND on N+1, tx_dv on N+2
        base = got.size(); ld0 = ld_count;
        send_str("abc");
        send_byte(8'h0A);
        chk("t1_lat_busy", bus.o_busy, 1);
        chk("t1_lat_no_dv", bus.o_tx_dv, 0);
        @(negedge i_clk);
        chk("t1_lat_dv", bus.o_tx_dv, 1);
        wait_idle("t1");
        chk("t1_count", got.size() - base, 4);
        chk("t1_b0", got[base], up(8'h61));
        chk("t1_b1", got[base+1], up(8'h62));
        chk("t1_b2", got[base+2], up(8'h63));
        chk("t1_b3", got[base+3], 8'h0A);
        chk("t1_len", bus.o_line_len, 4);
        chk("t1_line_done_once", ld_count - ld0, 1);
        chk("t1_drop", bus.o_drop_count, 0);

        // Full buffer with no terminator
        base = got.size();
        for (int i = 0; i < 64; i++) send_byte(8'h30 + 8'(i));
        chk("t2_busy_after_full", bus.o_busy, 1);
        wait_idle("t2");
        chk("t2_count", got.size() - base, 64);
        for (int i = 0; i < 64; i++) chk("t2_byte", got[base+i], up(8'h30 + 8'(i)));
        chk("t2_len", bus.o_line_len, 64);

        // Drops during WAIT_DONE, then a clean following line
        base = got.size();
        send_str("hi\n");
        wait_got(base + 1, "t3");
        for (int i = 0; i < 3; i++) send_byte(8'h55);
        wait_idle("t3a");
        chk("t3_drop", bus.o_drop_count, 3);
        chk("t3_b0", got[base], up(8'h68));
        chk("t3_b1", got[base+1], up(8'h69));
        chk("t3_b2", got[base+2], 8'h0A);
        base = got.size();
        send_str("ok\n");
        wait_idle("t3b");
        chk("t3_ok_count", got.size() - base, 3);
        chk("t3_ok0", got[base], up(8'h6F));
        chk("t3_ok1", got[base+1], up(8'h6B));
        chk("t3_len", bus.o_line_len, 3);

        // Transmitter held busy after the terminator
        hold_active = 1'b1;
        send_str("q\n");
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            chk("t4_no_dv_while_active", bus.o_tx_dv, 0);
        end
        hold_active = 1'b0;
        @(negedge i_clk);
        chk("t4_dv_after_release", bus.o_tx_dv, 1);
        wait_idle("t4");

        // Reset during WAIT_DONE of the second byte
        base = got.size();
        send_str("rs\n");
        wait_got(base + 2, "t5");
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("t5_tx_dv", bus.o_tx_dv, 0);
        chk("t5_tx_byte", bus.o_tx_byte, 0);
        chk("t5_busy", bus.o_busy, 0);
        chk("t5_line_done", bus.o_line_done, 0);
        chk("t5_line_len", bus.o_line_len, 0);
        chk("t5_drop", bus.o_drop_count, 0);
        repeat (30) @(negedge i_clk);
        chk("t5_no_more_tx", got.size() - base, 2);
        wait_idle("t5a");
        base = got.size();
        send_str("x\n");
        wait_idle("t5b");
        chk("t5_x_count", got.size() - base, 2);
        chk("t5_x0", got[base], up(8'h78));
        chk("t5_x1", got[base+1], 8'h0A);

        // Case handling on transmit
        base = got.size();
        send_str("aZ{\n");
        wait_idle("t6");
`ifdef UART_LINE_BUF_UPCASE_EN
        chk("t6_b0", got[base], 8'h41);
`else
        chk("t6_b0", got[base], 8'h61);
`endif
        chk("t6_b1", got[base+1], 8'h5A);
        chk("t6_b2", got[base+2], 8'h7B);
        chk("t6_b3", got[base+3], 8'h0A);
        chk("t6_len", bus.o_line_len, 4);

        // Random lines with random injections while busy
        for (int ln = 0; ln < 10; ln++) begin
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                send_byte(8'($urandom_range(8'h20, 8'h7E)));
                repeat ($urandom_range(0, 2)) @(negedge i_clk);
            end
            send_byte(TERM);
            for (int n = 0; n < 2000 && m_busy; n++) begin
                @(negedge i_clk);
                bus.i_rx_dv = ($urandom_range(0, 5) == 0);
                bus.i_rx_byte = 8'($urandom);
            end
            bus.i_rx_dv = 1'b0;
            wait_idle("rand");
        end

        // Drop counter saturation
        hold_active = 1'b1;
        send_str("z\n");
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            bus.i_rx_dv = 1'b1;
            bus.i_rx_byte = 8'h41;
        end
        @(negedge i_clk);
        bus.i_rx_dv = 1'b0;
        @(negedge i_clk);
        chk("t8_drop_saturated", bus.o_drop_count, 8'hFF);
        hold_active = 1'b0;
        wait_idle("t8");
        chk("t8_drop_held", bus.o_drop_count, 8'hFF);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
